// File: rtl/mul_stream_pkg.sv
// Shared constants and FSM state type for the streaming multiplier controller.
package mul_stream_pkg;

    localparam int unsigned WORD_W      = 64;
    localparam int unsigned N_IN_WORDS  = 4;
    localparam int unsigned N_OUT_WORDS = 8;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        WAIT_HI,
        WAIT_LO,
        DRAIN
    } state_t;

endpackage

// File: rtl/mul_word_pack.sv
// Operand packer: writes one streaming word into an indexed slice of a wide register.
module mul_word_pack #(
    parameter  int unsigned WORD_W  = 64,
    parameter  int unsigned N_WORDS = 4,
    localparam int unsigned IDX_W   = $clog2(N_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            idx,
    input  logic [WORD_W-1:0]           wdata,
    output logic [N_WORDS*WORD_W-1:0]   q
);

    // Slice write; the register only changes when the controller enables it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (wr_en) begin
            q[WORD_W*idx +: WORD_W] <= wdata;
        end
    end

endmodule

// File: rtl/mul_stream_ctrl.sv
// Streams two 256-bit operands in, runs an external multiplier via a
// start/busy handshake, and streams the 512-bit product out word by word.
module mul_stream_ctrl
    import mul_stream_pkg::*;
#(
    parameter int unsigned WORD_W      = mul_stream_pkg::WORD_W,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WORD_W-1:0]               in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WORD_W-1:0]               out_data,
    output logic                            out_last,
    output logic                            mul_start,
    input  logic                            mul_busy,
    output logic [N_IN_WORDS*WORD_W-1:0]    mul_a,
    output logic [N_IN_WORDS*WORD_W-1:0]    mul_b,
    input  logic [N_OUT_WORDS*WORD_W-1:0]   mul_c,
    output logic                            err
);

    localparam int unsigned IDX_W = $clog2(N_IN_WORDS);
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    IN_LAST  = 3'(N_IN_WORDS - 1);
    localparam logic [2:0]    OUT_LAST = 3'(N_OUT_WORDS - 1);

    state_t                           state_q, state_d;
    logic [2:0]                       wcnt_q, wcnt_d;
    logic                             start_q, start_d;
    logic                             err_q, err_d;
    logic [TW-1:0]                    tcnt_q, tcnt_d;
    logic                             rdy_q;
    logic [N_OUT_WORDS*WORD_W-1:0]    result_q;
    logic                             cap;
    logic                             wr_a, wr_b;

    assign mul_start = start_q;
    assign err       = err_q;

    mul_word_pack #(
        .WORD_W  (WORD_W),
        .N_WORDS (N_IN_WORDS)
    ) u_pack_a (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_a),
        .idx   (wcnt_q[IDX_W-1:0]),
        .wdata (in_data),
        .q     (mul_a)
    );

    mul_word_pack #(
        .WORD_W  (WORD_W),
        .N_WORDS (N_IN_WORDS)
    ) u_pack_b (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_b),
        .idx   (wcnt_q[IDX_W-1:0]),
        .wdata (in_data),
        .q     (mul_b)
    );

    // State, counters, multiplier control and product capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD_A;
            wcnt_q   <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            tcnt_q   <= '0;
            rdy_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            start_q <= start_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
            rdy_q   <= 1'b1;
            if (cap) begin
                result_q <= mul_c;
            end
        end
    end

    // Next-state, handshake outputs and timeout abort.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        start_d   = start_q;
        err_d     = 1'b0;
        tcnt_d    = tcnt_q;
        cap       = 1'b0;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        // rdy_q keeps in_ready low between reset release and the first edge
        in_ready  = rdy_q && ((state_q == LOAD_A) || (state_q == LOAD_B));
        out_valid = (state_q == DRAIN);
        out_last  = out_valid && (wcnt_q == OUT_LAST);
        out_data  = result_q[WORD_W*wcnt_q +: WORD_W];

        case (state_q)
            LOAD_A: begin
                if (in_valid && in_ready) begin
                    wr_a = 1'b1;
                    if (wcnt_q == IN_LAST) begin
                        wcnt_d  = '0;
                        state_d = LOAD_B;
                    end else begin
                        wcnt_d = wcnt_q + 3'd1;
                    end
                end
            end
            LOAD_B: begin
                if (in_valid && in_ready) begin
                    wr_b = 1'b1;
                    if (wcnt_q == IN_LAST) begin
                        wcnt_d  = '0;
                        start_d = 1'b1;
                        tcnt_d  = '0;
                        state_d = WAIT_HI;
                    end else begin
                        wcnt_d = wcnt_q + 3'd1;
                    end
                end
            end
            WAIT_HI: begin
                tcnt_d = tcnt_q + TW'(1);
                if (tcnt_q == TO_LAST) begin
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    tcnt_d  = '0;
                    state_d = LOAD_A;
                end else if (mul_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                tcnt_d = tcnt_q + TW'(1);
                if (!mul_busy) begin
                    cap     = 1'b1;
                    start_d = 1'b0;
                    tcnt_d  = '0;
                    state_d = DRAIN;
                end else if (tcnt_q == TO_LAST) begin
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    tcnt_d  = '0;
                    state_d = LOAD_A;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (wcnt_q == OUT_LAST) begin
                        wcnt_d  = '0;
                        state_d = LOAD_A;
                    end else begin
                        wcnt_d = wcnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = LOAD_A;
                wcnt_d  = '0;
                start_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_stream_ctrl.sv
// Scoreboard bench for mul_stream_ctrl with a behavioural multiplier beside it.
module tb_mul_stream_ctrl;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [63:0]    in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [63:0]    out_data;
    logic           out_last;
    logic           mul_start;
    logic           mul_busy;
    logic [255:0]   mul_a, mul_b;
    logic [511:0]   mul_c;
    logic           err;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } exp_t;

    exp_t   q[$];
    exp_t   e;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     hs_cnt = 0;
    int     ov_cnt = 0;
    int     rmode = 0;
    int     bmode = 1;
    logic         stalled = 1'b0;
    logic [63:0]  held_d;
    logic         held_l;

    mul_stream_ctrl #(
        .WORD_W      (64),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .mul_start (mul_start),
        .mul_busy  (mul_busy),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: idle 2 cycles, busy 4 cycles, then product; cleared by start low.
    logic [3:0] mcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_busy <= 1'b0; mcnt <= '0; mul_c <= '0;
        end else if (!mul_start) begin
            mul_busy <= 1'b0; mcnt <= '0; mul_c <= '0;
        end else if (bmode == 1) begin
            if (mcnt < 4'd2) begin
                mcnt <= mcnt + 4'd1;
            end else if (mcnt < 4'd6) begin
                mul_busy <= 1'b1; mcnt <= mcnt + 4'd1;
            end else if (mcnt == 4'd6) begin
                mul_busy <= 1'b0;
                mul_c    <= {256'b0, mul_a} * {256'b0, mul_b};
                mcnt     <= 4'd7;
            end
        end
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] prod(input logic [255:0] a, input logic [255:0] b);
        return {256'b0, a} * {256'b0, b};
    endfunction

    task automatic push_product(input logic [511:0] p);
        for (int i = 0; i < 8; i++) begin
            q.push_back({p[64*i +: 64], (i == 7)});
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks hold stability on stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else if (out_valid) begin
            ov_cnt++;
            if (stalled) begin
                chk("hold_data", out_data, held_d);
                chk("hold_last", out_last, held_l);
            end
            if (out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word actual %h required none", out_data);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", out_last, e.l);
                end
                hs_cnt++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held_d  = out_data;
                held_l  = out_last;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // Downstream ready: always 1, or repeating 1,0,0,1.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0) begin
                out_ready = 1'b1;
            end else begin
                out_ready = (ph == 0) || (ph == 3);
                ph = (ph + 1) % 4;
            end
        end
    end

    task automatic send_op(input logic [255:0] a, input logic [255:0] b, input int max_gap);
        logic [63:0] w;
        int n;
        for (int i = 0; i < 8; i++) begin
            w = (i < 4) ? a[64*i +: 64] : b[64*(i-4) +: 64];
            in_valid = 1'b1;
            in_data  = w;
            n = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                n++;
                if (n > 300) break;
            end
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout actual 0 required 1");
                in_valid = 1'b0;
                return;
            end
            if (i == 0) chk("start_low_before_load", mul_start, 1'b0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (max_gap > 0 && i < 7) begin
                repeat ($urandom_range(0, max_gap)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual %0d required 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] ones, a1, b1, a2, b2;
        int t0, t1, n, hs0, ov0;
        ones = '1;

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_mul_start", mul_start, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_mul_a", mul_a, 256'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_first_edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("in_ready_after_first_edge", in_ready, 1'b1);

        // 1 x 1
        for (int i = 0; i < 8; i++) q.push_back({(i == 0) ? 64'd1 : 64'd0, (i == 7)});
        send_op(256'd1, 256'd1, 0);
        wait_drain();

        // all-ones squared
        q.push_back({64'h1, 1'b0});
        q.push_back({64'h0, 1'b0});
        q.push_back({64'h0, 1'b0});
        q.push_back({64'h0, 1'b0});
        q.push_back({64'hFFFFFFFFFFFFFFFE, 1'b0});
        q.push_back({64'hFFFFFFFFFFFFFFFF, 1'b0});
        q.push_back({64'hFFFFFFFFFFFFFFFF, 1'b0});
        q.push_back({64'hFFFFFFFFFFFFFFFF, 1'b1});
        send_op(ones, ones, 0);
        wait_drain();

        // Backpressure 1,0,0,1 during drain
        a1 = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F0F0F0F0F0F0F0F, 64'h1111111111111111};
        b1 = {64'h8000000000000001, 64'h0000000000000003, 64'hDEADBEEFCAFEF00D, 64'h2222222222222222};
        rmode = 1;
        push_product(prod(a1, b1));
        send_op(a1, b1, 0);
        wait_drain();
        rmode = 0;

        // Two operations back-to-back with random input gaps
        a2 = {64'h0000000000000000, 64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000007};
        b2 = {64'h7FFFFFFFFFFFFFFF, 64'h0000000000000000, 64'h0000000100000000, 64'h00000000000000FF};
        push_product(prod(a2, b2));
        push_product(prod(b1, a2));
        send_op(a2, b2, 3);
        send_op(b1, a2, 3);
        wait_drain();

        // Timeout abort with mul_busy stuck low
        bmode = 0;
        ov0 = ov_cnt;
        send_op(a1, a2, 0);
        chk("start_high_after_load", mul_start, 1'b1);
        t0 = cyc;
        n = 0;
        forever begin
            @(negedge clk);
            if (err) break;
            n++;
            if (n > 200) break;
        end
        t1 = cyc;
        if (n > 200) begin
            checks++; errors++;
            $display("FAIL err_timeout actual 0 required 1");
        end else begin
            chk("err_delay", 32'(t1 - t0), 32'd64);
            chk("in_ready_after_abort", in_ready, 1'b1);
            chk("start_low_after_abort", mul_start, 1'b0);
            @(negedge clk);
            chk("err_one_cycle", err, 1'b0);
        end
        repeat (10) @(negedge clk);
        chk("no_out_valid_on_abort", 32'(ov_cnt - ov0), 32'd0);
        bmode = 1;
        @(posedge clk);
        #1;

        // Reset during the 3rd drain word
        hs0 = hs_cnt;
        push_product(prod(a1, b1));
        send_op(a1, b1, 0);
        n = 0;
        while (hs_cnt < hs0 + 2 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (hs_cnt < hs0 + 2) begin
            checks++; errors++;
            $display("FAIL drain_start_timeout actual %0d required %0d", hs_cnt - hs0, 2);
        end
        @(posedge clk);
        #1;
        chk("third_word_valid", out_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_start", mul_start, 1'b0);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_product(prod(a2, b1));
        send_op(a2, b1, 0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
